// File: rtl/cache_lru_if.sv
// rtl/cache_lru_if.sv - lookup/update/flush bundle between the hit stage and the LRU tracker
//
// Signals:
//   lookup_set  set index being resolved this cycle
//   lru_way     least-recently-used way of lookup_set (combinational)
//   update_en   one-cycle strobe recording an access
//   update_set  set index of the recorded access
//   update_way  way that was accessed
//   flush       one-cycle strobe returning all recency state to reset
// Modports: master = cache controller side, slave = LRU tracker side.
interface cache_lru_if #(
    parameter int SET_W = 2,
    parameter int WAY_W = 2
);
    logic [SET_W-1:0] lookup_set;
    logic [WAY_W-1:0] lru_way;
    logic             update_en;
    logic [SET_W-1:0] update_set;
    logic [WAY_W-1:0] update_way;
    logic             flush;

    modport master (
        output lookup_set,
        input  lru_way,
        output update_en,
        output update_set,
        output update_way,
        output flush
    );

    modport slave (
        input  lookup_set,
        output lru_way,
        input  update_en,
        input  update_set,
        input  update_way,
        input  flush
    );
endinterface

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set true-LRU age tracker for a set-associative cache
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   cache_lru_if.slave: lookup_set/lru_way read path, update_* and flush write path
// Each set keeps one age per way; ages in a set always form a permutation of
// 0..WAYS-1, age 0 = MRU, age WAYS-1 = LRU.
module cache_lru #(
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16
) (
    input  logic         clk,
    input  logic         rst,
    cache_lru_if.slave   bus
);
    localparam int SETS  = TOTAL_SIZE / WAYS;
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [WAY_W-1:0] LRU_AGE = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];
    logic [WAY_W-1:0] acc_age;
    logic [WAY_W-1:0] lru_way_c;

    // Exactly one way per set holds LRU_AGE, so OR-ing the matching indices
    // yields that way without a priority encoder.
    always_comb begin
        lru_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[bus.lookup_set][w] == LRU_AGE) begin
                lru_way_c = lru_way_c | WAY_W'(w);
            end
        end
    end

    assign bus.lru_way = lru_way_c;

    // Accessed way goes to age 0; only ways younger than it age by one,
    // which keeps the set a permutation and can never overflow.
    always_comb begin
        age_d   = age_q;
        acc_age = age_q[bus.update_set][bus.update_way];
        if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_d[s][w] = WAY_W'(WAYS - 1 - w);
                end
            end
        end else if (bus.update_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == bus.update_way) begin
                    age_d[bus.update_set][w] = '0;
                end else if (age_q[bus.update_set][w] < acc_age) begin
                    age_d[bus.update_set][w] = age_q[bus.update_set][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(WAYS - 1 - w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{SET_W};
endmodule

// File: tb/tb_cache_lru.sv
// tb/tb_cache_lru.sv - directed and random checks of cache_lru against a recency-list model
module tb_cache_lru;
    localparam int WAYS  = 4;
    localparam int SETS  = 4;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    // Per-set recency list, most recent first; the last entry is the LRU way.
    int   ord [SETS][$];

    cache_lru_if #(.SET_W(2), .WAY_W(2)) bus ();

    cache_lru #(.WAYS(WAYS), .TOTAL_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            ord[s].delete();
            for (int w = WAYS - 1; w >= 0; w--) ord[s].push_back(w);
        end
    endtask

    task automatic model_touch(input int s, input int w);
        for (int i = 0; i < ord[s].size(); i++) begin
            if (ord[s][i] == w) begin
                ord[s].delete(i);
                break;
            end
        end
        ord[s].push_front(w);
    endtask

    function automatic int model_age(input int s, input int w);
        for (int i = 0; i < ord[s].size(); i++) if (ord[s][i] == w) return i;
        return -1;
    endfunction

    // Inputs change 1ns after a rising edge; model follows the edge.
    task automatic do_cycle(input logic en, input int s, input int w, input logic fl);
        bus.update_en  = en;
        bus.update_set = 2'(s);
        bus.update_way = 2'(w);
        bus.flush      = fl;
        @(posedge clk);
        if (fl) model_reset();
        else if (en) model_touch(s, w);
        #1;
        bus.update_en = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // Full-state compare also covers the per-set permutation invariant.
    task automatic check_all(input string tag);
        for (int s = 0; s < SETS; s++) begin
            bus.lookup_set = 2'(s);
            #1;
            check($sformatf("%s_lru_s%0d", tag, s), 32'(bus.lru_way), 32'(ord[s][WAYS-1]));
            for (int w = 0; w < WAYS; w++) begin
                check($sformatf("%s_age_s%0dw%0d", tag, s, w), 32'(dut.age_q[s][w]), 32'(model_age(s, w)));
            end
        end
    endtask

    task automatic check_lru(input string tag, input int s, input int exp);
        bus.lookup_set = 2'(s);
        #1;
        check(tag, 32'(bus.lru_way), 32'(exp));
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        rst            = 1'b0;
        bus.lookup_set = '0;
        bus.update_en  = 1'b0;
        bus.update_set = '0;
        bus.update_way = '0;
        bus.flush      = 1'b0;
        model_reset();

        // In reset: every set reads way 0
        #1;
        for (int s = 0; s < SETS; s++) check_lru($sformatf("inreset_lru_s%0d", s), s, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_reset");

        // Set 1: touch ways 0,1,2 then 3
        do_cycle(1'b1, 1, 0, 1'b0);
        check_all("s1_w0");
        do_cycle(1'b1, 1, 1, 1'b0);
        check_all("s1_w1");
        do_cycle(1'b1, 1, 2, 1'b0);
        check_lru("s1_lru_after_012", 1, 3);
        check_lru("s0_untouched", 0, 0);
        check_lru("s2_untouched", 2, 0);
        check_lru("s3_untouched", 3, 0);
        do_cycle(1'b1, 1, 3, 1'b0);
        check_lru("s1_lru_after_3", 1, 0);
        check_all("s1_w3");

        // Asynchronous reset between edges
        do_cycle(1'b1, 1, 0, 1'b0);
        check_lru("pre_async_rst", 1, 1);
        rst = 1'b0;
        #1;
        check_lru("async_rst_low", 1, 0);
        model_reset();
        rst = 1'b1;
        #1;
        check_lru("async_rst_released", 1, 0);
        @(posedge clk);
        #1;
        check_all("post_async_rst");

        // Same-cycle lookup and update of set 1: no bypass
        bus.lookup_set = 2'd1;
        bus.update_en  = 1'b1;
        bus.update_set = 2'd1;
        bus.update_way = 2'd0;
        #1;
        check("same_cycle_pre", 32'(bus.lru_way), 32'd0);
        @(posedge clk);
        model_touch(1, 0);
        #1;
        bus.update_en = 1'b0;
        check("same_cycle_post", 32'(bus.lru_way), 32'd1);

        // Set 2: touch already-MRU way 3, then way 0
        do_cycle(1'b1, 2, 3, 1'b0);
        check_lru("s2_mru_touch_lru", 2, 0);
        for (int w = 0; w < WAYS; w++)
            check($sformatf("s2_mru_touch_age_w%0d", w), 32'(dut.age_q[2][w]), 32'(WAYS - 1 - w));
        do_cycle(1'b1, 2, 0, 1'b0);
        check_lru("s2_w0_lru", 2, 1);
        check_all("s2_w0");

        // Flush wins over a simultaneous update
        do_cycle(1'b1, 0, 2, 1'b0);
        do_cycle(1'b1, 3, 1, 1'b0);
        do_cycle(1'b1, 0, 0, 1'b1);
        for (int s = 0; s < SETS; s++) check_lru($sformatf("flush_lru_s%0d", s), s, 0);
        check("flush_s0w0_not_mru", 32'(dut.age_q[0][0]), 32'(WAYS - 1));
        check_all("flush");

        // Random stream with occasional flushes and idle cycles
        for (int i = 0; i < 1000; i++) begin
            do_cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, SETS - 1)),
                     int'($urandom_range(0, WAYS - 1)), 1'($urandom_range(0, 49) == 0));
            check_all("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
